// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the ALU flag unit.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_PASSB = 4'h1;
    localparam logic [3:0] OP_NOTA  = 4'h2;
    localparam logic [3:0] OP_NOTB  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_LSL   = 4'hA;
    localparam logic [3:0] OP_LSR   = 4'hB;
    localparam logic [3:0] OP_ASR   = 4'hC;
    localparam logic [3:0] OP_ROL   = 4'hD;
    localparam logic [3:0] OP_ROR   = 4'hE;
    localparam logic [3:0] OP_MUL   = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_flags_unit_if.sv
// Operand/result bus between the register file and the ALU flag unit.
interface alu_flags_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             out_valid;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out, out_hi, out_valid, flags
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out, out_hi, out_valid, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // product is the accumulator after the step taken at the coming edge;
    // done marks the edge on which that step is the last one.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_flags_unit.sv
// 8-bit ALU stage with {Z,C,N,O} flag register, registered result and a
// sequential multiplier that back-pressures the register file while busy.
module alu_flags_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_flags_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_t             state;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   hi_q;
    logic [3:0]         flags_q;
    logic               valid_q;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum;
    logic               c_next;
    logic               o_next;
    logic [3:0]         flags_alu;
    logic [3:0]         flags_mul;

    assign bus.in_ready  = (state == IDLE) && !mul_busy;
    assign bus.out       = out_q;
    assign bus.out_hi    = hi_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = valid_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        res    = '0;
        sum    = '0;
        c_next = flags_q[FLAG_C];
        o_next = flags_q[FLAG_O];
        case (bus.op)
            OP_PASSA: res = bus.a;
            OP_PASSB: res = bus.b;
            OP_NOTA:  res = ~bus.a;
            OP_NOTB:  res = ~bus.b;
            OP_ADD, OP_ADC: begin
                sum    = {1'b0, bus.a} + {1'b0, bus.b}
                       + {{WIDTH{1'b0}}, (bus.op == OP_ADC) && flags_q[FLAG_C]};
                res    = sum[MSB:0];
                c_next = sum[WIDTH];
                o_next = (bus.a[MSB] == bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                res    = bus.a - bus.b;
                c_next = (bus.a >= bus.b);
                o_next = (bus.a[MSB] != bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
            end
            OP_AND:   res = bus.a & bus.b;
            OP_OR:    res = bus.a | bus.b;
            OP_XOR:   res = bus.a ^ bus.b;
            OP_LSL: begin
                res    = {bus.a[MSB-1:0], 1'b0};
                c_next = bus.a[MSB];
            end
            OP_LSR: begin
                res    = {1'b0, bus.a[MSB:1]};
                c_next = bus.a[0];
            end
            OP_ASR: begin
                res    = {bus.a[MSB], bus.a[MSB:1]};
                c_next = bus.a[0];
            end
            OP_ROL: begin
                res    = {bus.a[MSB-1:0], flags_q[FLAG_C]};
                c_next = bus.a[MSB];
            end
            OP_ROR: begin
                res    = {flags_q[FLAG_C], bus.a[MSB:1]};
                c_next = bus.a[0];
            end
            default: res = '0;
        endcase

        flags_alu[FLAG_Z] = (res == '0);
        flags_alu[FLAG_C] = c_next;
        flags_alu[FLAG_N] = res[MSB];
        flags_alu[FLAG_O] = o_next;

        flags_mul[FLAG_Z] = (product == '0);
        flags_mul[FLAG_C] = (product[2*WIDTH-1:WIDTH] != '0);
        flags_mul[FLAG_N] = product[2*WIDTH-1];
        flags_mul[FLAG_O] = flags_q[FLAG_O];
    end

    // out_valid is a pulse: cleared every cycle unless a result lands on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state   <= IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state <= MUL;
                    end else if (accept) begin
                        out_q   <= res;
                        hi_q    <= '0;
                        flags_q <= flags_alu;
                        valid_q <= 1'b1;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        out_q   <= product[WIDTH-1:0];
                        hi_q    <= product[2*WIDTH-1:WIDTH];
                        flags_q <= flags_mul;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_flags_unit.md
Name: alu_flags_unit

Overview:
- 8-bit ALU stage directly downstream of the register file.
- Operand A comes from register-file output O1 and operand B from O2; the result is written back to the register file or memory.
- Holds the 4-bit flag register {Z,C,N,O} and a registered result.
- Single-cycle ops complete with 1-cycle latency. MUL is a sequential 8-iteration shift-add with busy back-pressure.

Parameters:
- WIDTH, 8, operand/result width; MUL iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- op  in  4  operation select
- a  in  WIDTH  operand A (RF O1)
- b  in  WIDTH  operand B (RF O2)
- out  out  WIDTH  registered result (MUL: product low byte)
- out_hi  out  WIDTH  MUL product high byte; 0 for other ops
- out_valid  out  1  one-cycle pulse, result/flags updated
- flags  out  4  {Z,C,N,O}, bit3=Z

Behaviour:
- Reset (async, rst_n=0):
  - out=0, out_hi=0, flags=0, out_valid=0, in_ready=1, state=IDLE.
  - Any in-flight MUL is aborted with no out_valid.
- States: IDLE, MUL.
- Opcodes and results:
  - 0 A; 1 B; 2 ~A; 3 ~B
  - 4 A+B; 5 A+B+C; 6 A-B
  - 7 AND; 8 OR; 9 XOR
  - A LSL A; B LSR A; C ASR A
  - D rotate-left A through C; E rotate-right A through C
  - F MUL
- IDLE, single-cycle op accepted at edge k:
  - out, out_hi=0 and flags are updated at edge k.
  - out_valid=1 for the cycle after edge k.
  - in_ready stays 1, so back-to-back issue every cycle is allowed.
  - op 5 uses the C held in the flag register, i.e. the C produced by the previous op.
- Flag rules (all arithmetic is modulo 2^WIDTH):
  - Z: set when result==0 for every op.
  - N: result[7] for every op except MUL.
  - C, add (4, 5): carry-out.
  - C, sub (6): 1 when A>=B unsigned (no borrow).
  - C, shifts/rotates: the bit shifted out.
  - C, ops 0-3 and 7-9: unchanged.
  - O, add: (A7==B7) && (R7!=A7).
  - O, sub: (A7!=B7) && (R7!=A7).
  - O, all other ops except MUL: unchanged.
- MUL (op F) accepted at edge k:
  - Latch A and B; go to MUL; iteration count=0; in_ready=0.
  - Edges k+1..k+8 perform one shift-add step each.
  - At edge k+8: out=low byte, out_hi=high byte, out_valid=1, state=IDLE, in_ready=1.
  - MUL flags: Z=(16-bit product==0); C=(out_hi!=0); N=product[15]; O unchanged.
  - in_ready is low for exactly 8 cycles. in_valid during MUL is ignored (not accepted).
- out_valid is never high for two consecutive cycles from one accepted op.
- out, out_hi and flags hold their values between ops.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_PASSA..OP_MUL;
  - flag bit indices FLAG_Z/C/N/O;
  - the state enum (IDLE, MUL).
- One sub-module, alu_mul_seq: shift-add multiplier with start, 3-bit count, done and 16-bit product.
- The combinational op decode stays in the top module.

Test Plan:
- Reset: rst_n=0 -> out=0x00, out_hi=0x00, flags=0000, in_ready=1, out_valid=0.
- ADD a=0x7F, b=0x01 -> next cycle out=0x80, out_valid=1, flags Z0 C0 N1 O1.
- SUB a=0x05, b=0x05 -> out=0x00, Z1 C1 N0 O0. Then SUB a=0x03, b=0x05 -> out=0xFE, C0 N1.
- ADD 0xFF+0x01 -> out=0x00, Z1 C1. Back-to-back ADC 0x01+0x01 on the next cycle -> out=0x03. Then rotate-left a=0x81 with C=0 -> out=0x02, C1.
- MUL a=0x12, b=0x34 -> in_ready low for 8 cycles, out_valid exactly 8 cycles after accept, out=0xA8, out_hi=0x03, Z0 C1 N0. in_valid held high during MUL is not accepted.
- Assert rst_n=0 at MUL iteration 4 -> outputs zero immediately, no out_valid. After release, in_ready=1 and ADD 0x01+0x02 gives out=0x03.
